// File: rtl/wb_reg_file_pkg.sv
// Shared sizing constants for the write-back stage and register file.
// Also holds the per-register write-enable helper used by the array.
package wb_reg_file_pkg;

  localparam int data_size = 32;
  localparam int addr_size = 5;
  localparam int NUM_REGS  = 1 << addr_size;
  localparam int NUM_READ_PORTS = 2;
  localparam logic [addr_size-1:0] REG_ZERO = '0;

  // A register index is writable only when it is not the hardwired zero.
  function automatic logic is_writable(input logic [addr_size-1:0] idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/wb_data_sel.sv
// Write-back data select: memory read data versus ALU/PC result.
// The result is used both for the array write and for forwarding.
import wb_reg_file_pkg::*;

module wb_data_sel (
  input  logic                 mem_to_reg,
  input  logic [data_size-1:0] dm_read_data,
  input  logic [data_size-1:0] wd_data,
  output logic [data_size-1:0] write_data
);

  assign write_data = mem_to_reg ? dm_read_data : wd_data;

endmodule

// File: rtl/wb_reg_file.sv
// Write-back stage plus 32-entry architectural register file with two
// combinational read ports, same-cycle write-through bypass and a commit counter.
import wb_reg_file_pkg::*;

module wb_reg_file (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 WB_MemtoReg,
  input  logic                 WB_RegWrite,
  input  logic [data_size-1:0] WB_DM_Read_Data,
  input  logic [data_size-1:0] WB_WD_out,
  input  logic [addr_size-1:0] WB_WR_out,
  input  logic [addr_size-1:0] Read_addr_1,
  input  logic [addr_size-1:0] Read_addr_2,
  output logic [data_size-1:0] Read_data_1,
  output logic [data_size-1:0] Read_data_2,
  output logic [data_size-1:0] WB_Write_Data,
  output logic                 WB_Commit,
  output logic [31:0]          Commit_count
);

  logic [data_size-1:0] reg_file_reg [NUM_REGS];
  logic [31:0]          commit_count_reg;
  logic [31:0]          commit_count_next;

  logic [addr_size-1:0] rd_addr [NUM_READ_PORTS];
  logic [data_size-1:0] rd_data [NUM_READ_PORTS];

  wb_data_sel u_wb_data_sel (
    .mem_to_reg   (WB_MemtoReg),
    .dm_read_data (WB_DM_Read_Data),
    .wd_data      (WB_WD_out),
    .write_data   (WB_Write_Data)
  );

  assign WB_Commit         = WB_RegWrite && is_writable(WB_WR_out) && !rst;
  assign commit_count_next = commit_count_reg + 32'd1;
  assign Commit_count      = commit_count_reg;

  // Entry 0 is cleared by reset and never written, since a commit needs a nonzero index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file_reg[i] <= '0;
      end
      commit_count_reg <= '0;
    end else if (WB_Commit) begin
      reg_file_reg[WB_WR_out] <= WB_Write_Data;
      commit_count_reg        <= commit_count_next;
    end
  end

  assign rd_addr[0]  = Read_addr_1;
  assign rd_addr[1]  = Read_addr_2;
  assign Read_data_1 = rd_data[0];
  assign Read_data_2 = rd_data[1];

  generate
    for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_read_port
      always_comb begin
        rd_data[gi] = reg_file_reg[rd_addr[gi]];
        if (rst || (rd_addr[gi] == REG_ZERO)) begin
          rd_data[gi] = '0;
        end else if (WB_Commit && (rd_addr[gi] == WB_WR_out)) begin
          rd_data[gi] = WB_Write_Data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_wb_reg_file.sv
// Directed bench for wb_reg_file: reset, mux, bypass, r0, disabled write, wrap.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_MemtoReg;
  logic        WB_RegWrite;
  logic [31:0] WB_DM_Read_Data;
  logic [31:0] WB_WD_out;
  logic [4:0]  WB_WR_out;
  logic [4:0]  Read_addr_1;
  logic [4:0]  Read_addr_2;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic [31:0] WB_Write_Data;
  logic        WB_Commit;
  logic [31:0] Commit_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_reg_file dut (
    .clk             (clk),
    .rst             (rst),
    .WB_MemtoReg     (WB_MemtoReg),
    .WB_RegWrite     (WB_RegWrite),
    .WB_DM_Read_Data (WB_DM_Read_Data),
    .WB_WD_out       (WB_WD_out),
    .WB_WR_out       (WB_WR_out),
    .Read_addr_1     (Read_addr_1),
    .Read_addr_2     (Read_addr_2),
    .Read_data_1     (Read_data_1),
    .Read_data_2     (Read_data_2),
    .WB_Write_Data   (WB_Write_Data),
    .WB_Commit       (WB_Commit),
    .Commit_count    (Commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("ok   %-14s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_wb(input logic rw, input logic m2r, input logic [31:0] dm,
                        input logic [31:0] wd, input logic [4:0] wr);
    WB_RegWrite     = rw;
    WB_MemtoReg     = m2r;
    WB_DM_Read_Data = dm;
    WB_WD_out       = wd;
    WB_WR_out       = wr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    Read_addr_1 = 5'd0;
    Read_addr_2 = 5'd0;
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    step();

    // Reset state
    Read_addr_1 = 5'd5;
    Read_addr_2 = 5'd8;
    #1;
    check("rst_rd1", Read_data_1, 32'h0);
    check("rst_cnt", Commit_count, 32'h0);

    // Preload r5 and r8
    rst = 1'b0;
    set_wb(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd5);
    #1;
    check("commit_r5", {31'b0, WB_Commit}, 32'h1);
    step();
    check("cnt1", Commit_count, 32'd1);

    set_wb(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8);
    #1;
    check("mux_dm", WB_Write_Data, 32'hDEAD_BEEF);
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    Read_addr_1 = 5'd8;
    Read_addr_2 = 5'd5;
    #1;
    check("rd_r8_dm", Read_data_1, 32'hDEAD_BEEF);
    check("rd_r5", Read_data_2, 32'h0000_0055);
    check("cnt2", Commit_count, 32'd2);

    set_wb(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8);
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("rd_r8_wd", Read_data_1, 32'h0000_1234);

    // Bypass: r9 holds an old value, new write visible on both ports pre-edge
    set_wb(1'b1, 1'b0, 32'h0, 32'h1111_1111, 5'd9);
    step();
    set_wb(1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd9);
    Read_addr_1 = 5'd9;
    Read_addr_2 = 5'd9;
    #1;
    check("byp_rd1", Read_data_1, 32'hA5A5_A5A5);
    check("byp_rd2", Read_data_2, 32'hA5A5_A5A5);
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("post_byp", Read_data_2, 32'hA5A5_A5A5);
    check("cnt5", Commit_count, 32'd5);

    // Register 0 write is not a commit
    set_wb(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    Read_addr_1 = 5'd0;
    #1;
    check("r0_commit", {31'b0, WB_Commit}, 32'h0);
    check("r0_wbdata", WB_Write_Data, 32'hFFFF_FFFF);
    check("r0_rd", Read_data_1, 32'h0);
    step();
    check("r0_rd_post", Read_data_1, 32'h0);
    check("r0_cnt", Commit_count, 32'd5);

    // Disabled write leaves r3 alone and does not bypass
    set_wb(1'b1, 1'b0, 32'h0, 32'h0000_0033, 5'd3);
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0000_0077, 5'd3);
    Read_addr_1 = 5'd3;
    #1;
    check("dis_nobyp", Read_data_1, 32'h0000_0033);
    check("dis_commit", {31'b0, WB_Commit}, 32'h0);
    step();
    check("dis_rd", Read_data_1, 32'h0000_0033);
    check("cnt6", Commit_count, 32'd6);

    // Reset mid-stream with a concurrent write to r5
    rst = 1'b1;
    set_wb(1'b1, 1'b0, 32'h0, 32'h0000_0BAD, 5'd5);
    Read_addr_1 = 5'd5;
    Read_addr_2 = 5'd8;
    #1;
    check("rsti_rd1", Read_data_1, 32'h0);
    check("rsti_commit", {31'b0, WB_Commit}, 32'h0);
    check("rsti_wbdata", WB_Write_Data, 32'h0000_0BAD);
    step();
    rst = 1'b0;
    set_wb(1'b1, 1'b0, 32'h0, 32'h0000_0066, 5'd6);
    #1;
    check("rsto_r5", Read_data_1, 32'h0);
    check("rsto_r8", Read_data_2, 32'h0);
    check("rsto_cnt", Commit_count, 32'h0);
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    Read_addr_1 = 5'd6;
    #1;
    check("first_wr", Read_data_1, 32'h0000_0066);
    check("first_cnt", Commit_count, 32'd1);

    // Counter wrap
    force dut.commit_count_reg = 32'hFFFF_FFFF;
    #1;
    check("cnt_forced", Commit_count, 32'hFFFF_FFFF);
    set_wb(1'b1, 1'b0, 32'h0, 32'h0000_0007, 5'd7);
    #1;
    release dut.commit_count_reg;
    step();
    set_wb(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("cnt_wrap", Commit_count, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
# wb_reg_file

Write-back stage and architectural register file of the 5-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the write-back data, and commits it to a 32-entry register file. Serves the two ID-stage read ports with same-cycle write-through bypass, and counts committed register writes for debug and performance visibility.

## Interface
- data_size, 32, width of a register and of all data ports
- addr_size, 5, register index width; file depth is 2^addr_size

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- WB_MemtoReg  input  1  1 = write back DM read data, 0 = write back ALU/PC result
- WB_RegWrite  input  1  register write enable from WB stage
- WB_DM_Read_Data  input  data_size  data memory read value
- WB_WD_out  input  data_size  ALU/PC result value
- WB_WR_out  input  addr_size  destination register index
- Read_addr_1  input  addr_size  ID read port 1 index (rs)
- Read_addr_2  input  addr_size  ID read port 2 index (rt)
- Read_data_1  output  data_size  port 1 data, combinational
- Read_data_2  output  data_size  port 2 data, combinational
- WB_Write_Data  output  data_size  selected write-back value, combinational, to the forwarding unit
- WB_Commit  output  1  combinational: a real write commits this cycle
- Commit_count  output  32  registered count of committed writes

## Operation
- WB_Write_Data = WB_MemtoReg ? WB_DM_Read_Data : WB_WD_out; driven regardless of WB_RegWrite.
- WB_Commit = WB_RegWrite && (WB_WR_out != 0) && !rst.
- On rising edge with WB_Commit: reg[WB_WR_out] <= WB_Write_Data; Commit_count <= Commit_count + 1.
- Register 0: never written, always reads 0, even if WB_WR_out = 0 with WB_RegWrite = 1 (no commit, no count).
- Read port n: if rst, 0; else if Read_addr_n == 0, 0; else if WB_Commit and Read_addr_n == WB_WR_out, WB_Write_Data (bypass); else reg[Read_addr_n].
- Both ports may hit the same index and the bypass simultaneously; both return the bypassed value.
- Commit_count wraps 0xFFFFFFFF -> 0 with no flag.
- No stall input: WB stalls arrive as WB_RegWrite = 0 (held pipeline register), and a held write must not be re-counted by the source; this block commits every cycle WB_Commit is high.

## Timing
- Reset: on a rising edge with rst = 1, all registers and Commit_count become 0; any concurrent write is discarded. While rst is high, Read_data_1/2 = 0, WB_Commit = 0; WB_Write_Data still follows its mux.
- Reset mid-stream: the write presented in the reset cycle is lost; the first write accepted is the one presented in the first cycle with rst = 0.
- Write latency: 1 edge to array; 0 cycles to read ports via bypass.
- Commit_count reflects commits up to and including the previous edge.

## Structure
- Shared package: data_size, addr_size, REG_ZERO (= 0), register count constant.
- One natural sub-module: wb_data_sel (2:1 write-back data mux, generating WB_Write_Data); array, bypass and counter stay in wb_reg_file.

## Test plan
- Reset: preload via writes, assert rst one cycle with WB_RegWrite = 1, WR = 5 -> all reads 0, Commit_count = 0, reg5 reads 0 after release.
- Mux and write: MemtoReg = 1, DM = 0xDEADBEEF, WD = 0x1234, WR = 8, RegWrite = 1 -> next cycle Read_addr_1 = 8 gives 0xDEADBEEF; repeat MemtoReg = 0 -> 0x00001234.
- Bypass: same cycle WR = 9, data 0xA5A5A5A5, Read_addr_1 = Read_addr_2 = 9 -> both ports 0xA5A5A5A5 before the edge, old value not visible.
- Register 0: RegWrite = 1, WR = 0, data 0xFFFFFFFF -> WB_Commit = 0, read of 0 returns 0, Commit_count unchanged.
- Disabled write: RegWrite = 0, WR = 3, data 0x77 -> reg3 unchanged, no bypass on read of 3.
- Counter: force Commit_count to 0xFFFFFFFF, one commit -> 0x00000000.
